// File: rtl/instruction_sequencer.sv
// Fetch/dispatch controller: fetches 3-byte instructions from synchronous RAM, resolves
// NOP/JMP/JZ/HALT locally and offers all other opcodes to the control unit via valid/ready.
module instruction_sequencer #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             ram_rd,
    output logic [7:0]       ram_addr,
    input  logic [7:0]       ram_rdata,
    input  logic             zero_flag,
    output logic [23:0]      cmd_word,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       pc,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_JMP  = 8'h80;
    localparam logic [7:0] OP_JZ   = 8'h81;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, DISPATCH, HALT} state_t;

    state_t     state;
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] cur_op;
    logic       is_local;
    logic       retire;

    // Dispatch decodes the assembled command word so it stays stable while waiting.
    assign cur_op   = cmd_word[23:16];
    assign is_local = (cur_op == OP_NOP) || (cur_op == OP_JMP) ||
                      (cur_op == OP_JZ)  || (cur_op == OP_HALT);
    assign retire   = (state == DISPATCH) && (is_local || cmd_ready);

    assign ram_rd    = (state == F0) || (state == F1) || (state == F2);
    assign ram_addr  = ram_rd ? pc : '0;
    assign cmd_valid = (state == DISPATCH) && !is_local;
    assign halted    = (state == HALT);
    assign busy      = (state != IDLE) && (state != HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            opcode   <= '0;
            operand1 <= '0;
            cmd_word <= '0;
            retired  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= F0;
                end
                F0: begin
                    pc    <= pc + 8'd1;
                    state <= F1;
                end
                F1: begin
                    opcode <= ram_rdata;
                    pc     <= pc + 8'd1;
                    state  <= F2;
                end
                F2: begin
                    operand1 <= ram_rdata;
                    pc       <= pc + 8'd1;
                    state    <= F3;
                end
                F3: begin
                    cmd_word <= {opcode, operand1, ram_rdata};
                    state    <= DISPATCH;
                end
                DISPATCH: begin
                    if (retire) begin
                        if (retired != '1) retired <= retired + CNT_W'(1);
                        if (cur_op == OP_JMP || (cur_op == OP_JZ && zero_flag))
                            pc <= cmd_word[15:8];
                        if (cur_op == OP_HALT) state <= HALT;
                        else                   state <= run ? F0 : IDLE;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer: default instance plus a
// RESET_PC=8'hFE instance for the PC wrap-around case, both fed by a synchronous RAM model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem [256];

    logic        run = 1'b0, zero_flag = 1'b0, cmd_ready = 1'b0;
    logic        ram_rd, cmd_valid, halted, busy;
    logic [7:0]  ram_addr, ram_rdata, pc;
    logic [23:0] cmd_word;
    logic [15:0] retired;

    logic        run2 = 1'b0, cmd_ready2 = 1'b0;
    logic        ram_rd2, cmd_valid2, halted2, busy2;
    logic [7:0]  ram_addr2, ram_rdata2, pc2;
    logic [23:0] cmd_word2;
    logic [15:0] retired2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd)  ram_rdata  <= mem[ram_addr];
        if (ram_rd2) ram_rdata2 <= mem[ram_addr2];
    end

    instruction_sequencer #(.RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .ram_rd(ram_rd), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .zero_flag(zero_flag), .cmd_word(cmd_word),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .pc(pc), .halted(halted),
        .busy(busy), .retired(retired)
    );

    instruction_sequencer #(.RESET_PC(8'hFE), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .ram_rd(ram_rd2), .ram_addr(ram_addr2),
        .ram_rdata(ram_rdata2), .zero_flag(1'b0), .cmd_word(cmd_word2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .pc(pc2), .halted(halted2),
        .busy(busy2), .retired(retired2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; run2 = 1'b0;
        tick(2);
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
        total++; if (cmd_word !== 24'h0) begin bad++; $display("FAIL reset_cmd_word got=%h exp=000000", cmd_word); end
        total++; if ({cmd_valid, ram_rd, halted, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {cmd_valid, ram_rd, halted, busy}); end
        total++; if (ram_addr !== 8'h00) begin bad++; $display("FAIL reset_ram_addr got=%h exp=00", ram_addr); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        total++; if (pc2 !== 8'hFE) begin bad++; $display("FAIL reset_pc2 got=%h exp=fe", pc2); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++; if (ram_rd !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_quiet cyc=%0d ram_rd=%b busy=%b exp=0,0", i, ram_rd, busy); end
        end
    endtask

    task automatic test_basic_fetch();
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h02;
        cmd_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            total++; if (ram_rd !== 1'b1 || ram_addr !== 8'(i)) begin bad++; $display("FAIL fetch_addr i=%0d rd=%b addr=%h exp=1,%h", i, ram_rd, ram_addr, 8'(i)); end
        end
        tick(1);
        total++; if (ram_rd !== 1'b0 || cmd_valid !== 1'b0) begin bad++; $display("FAIL f3_quiet rd=%b valid=%b exp=0,0", ram_rd, cmd_valid); end
        tick(1);
        run = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd_word !== 24'h010002) begin bad++; $display("FAIL basic_cmd valid=%b word=%h exp=1,010002", cmd_valid, cmd_word); end
        tick(1);
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", cmd_valid); end
        total++; if (pc !== 8'h03 || retired !== 16'd1) begin bad++; $display("FAIL basic_retire pc=%h retired=%0d exp=03,1", pc, retired); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        mem[3] = 8'h12; mem[4] = 8'h34; mem[5] = 8'h56;
        cmd_ready = 1'b0; run = 1'b1;
        tick(5);
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (cmd_valid !== 1'b1 || cmd_word !== 24'h123456 || ram_rd !== 1'b0) begin bad++; $display("FAIL bp_hold i=%0d valid=%b word=%h rd=%b exp=1,123456,0", i, cmd_valid, cmd_word, ram_rd); end
            total++; if (retired !== 16'd1) begin bad++; $display("FAIL bp_no_retire i=%0d retired=%0d exp=1", i, retired); end
            tick(1);
        end
        cmd_ready = 1'b1;
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL bp_still_valid got=%b exp=1", cmd_valid); end
        tick(1);
        total++; if (cmd_valid !== 1'b0 || retired !== 16'd2 || pc !== 8'h06) begin bad++; $display("FAIL bp_retire valid=%b retired=%0d pc=%h exp=0,2,06", cmd_valid, retired, pc); end
    endtask

    task automatic test_control_flow();
        mem[0] = 8'h81; mem[1] = 8'h09; mem[2] = 8'h00;
        mem[9] = 8'hFF; mem[10] = 8'h00; mem[11] = 8'h00;
        do_reset();
        zero_flag = 1'b0; run = 1'b1;
        tick(5);
        run = 1'b0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL jz_no_valid got=%b exp=0", cmd_valid); end
        tick(1);
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL jz_not_taken pc=%h exp=03", pc); end
        do_reset();
        zero_flag = 1'b1; run = 1'b1;
        tick(5);
        tick(1);
        total++; if (pc !== 8'h09) begin bad++; $display("FAIL jz_taken pc=%h exp=09", pc); end
        total++; if (ram_rd !== 1'b1 || ram_addr !== 8'h09) begin bad++; $display("FAIL jz_target_fetch rd=%b addr=%h exp=1,09", ram_rd, ram_addr); end
        tick(5);
        total++; if (halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd2) begin bad++; $display("FAIL halt_state halted=%b busy=%b retired=%0d exp=1,0,2", halted, busy, retired); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            total++; if (ram_rd !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_sticky i=%0d rd=%b halted=%b exp=0,1", i, ram_rd, halted); end
        end
        run = 1'b0; zero_flag = 1'b0;
    endtask

    task automatic test_wraparound();
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h05; mem[8'h00] = 8'h06;
        cmd_ready2 = 1'b1; run2 = 1'b1;
        tick(1);
        total++; if (ram_addr2 !== 8'hFE) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fe", ram_addr2); end
        tick(2);
        total++; if (ram_addr2 !== 8'h00 || ram_rd2 !== 1'b1) begin bad++; $display("FAIL wrap_addr2 addr=%h rd=%b exp=00,1", ram_addr2, ram_rd2); end
        tick(2);
        run2 = 1'b0;
        total++; if (cmd_valid2 !== 1'b1 || cmd_word2 !== 24'h010506) begin bad++; $display("FAIL wrap_cmd valid=%b word=%h exp=1,010506", cmd_valid2, cmd_word2); end
        tick(1);
        total++; if (pc2 !== 8'h01 || retired2 !== 16'd1) begin bad++; $display("FAIL wrap_pc pc=%h retired=%0d exp=01,1", pc2, retired2); end
    endtask

    task automatic test_stop_and_reset();
        mem[0] = 8'h05; mem[1] = 8'hAA; mem[2] = 8'hBB;
        mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
        do_reset();
        cmd_ready = 1'b1; run = 1'b1;
        tick(2);
        run = 1'b0;
        tick(1);
        total++; if (busy !== 1'b1 || ram_addr !== 8'h02) begin bad++; $display("FAIL stop_continues busy=%b addr=%h exp=1,02", busy, ram_addr); end
        tick(2);
        total++; if (cmd_valid !== 1'b1 || cmd_word !== 24'h05AABB) begin bad++; $display("FAIL stop_cmd valid=%b word=%h exp=1,05aabb", cmd_valid, cmd_word); end
        tick(1);
        total++; if (busy !== 1'b0 || retired !== 16'd1 || pc !== 8'h03) begin bad++; $display("FAIL stop_idle busy=%b retired=%0d pc=%h exp=0,1,03", busy, retired, pc); end
        tick(1);
        total++; if (ram_rd !== 1'b0) begin bad++; $display("FAIL stop_no_fetch rd=%b exp=0", ram_rd); end
        cmd_ready = 1'b0; run = 1'b1;
        tick(5);
        total++; if (cmd_valid !== 1'b1 || cmd_word !== 24'h223344) begin bad++; $display("FAIL pre_rst_cmd valid=%b word=%h exp=1,223344", cmd_valid, cmd_word); end
        rst = 1'b1; run = 1'b0;
        tick(1);
        rst = 1'b0;
        total++; if (cmd_valid !== 1'b0 || pc !== 8'h00 || retired !== 16'd0) begin bad++; $display("FAIL rst_mid_op valid=%b pc=%h retired=%0d exp=0,00,0", cmd_valid, pc, retired); end
        total++; if (cmd_word !== 24'h0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_op_word word=%h busy=%b exp=000000,0", cmd_word, busy); end
        tick(2);
        total++; if (ram_rd !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_stays_idle rd=%b busy=%b exp=0,0", ram_rd, busy); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_control_flow();
        test_wraparound();
        test_stop_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/dispatch controller for the 8-bit processor. Owns the program counter, reads 3-byte instructions (opcode, operand1, operand2) from the synchronous RAM, and assembles them into the 24-bit command word for the control unit. Resolves control-flow opcodes (NOP, JMP, JZ, HALT) locally, hands every other opcode to the execute side over a valid/ready handshake, and counts retired instructions. Sits between RandomAcessMemory and the control unit, replacing the ad-hoc PC_inc/MAR_load/IR_load strobing.

## Interface
- RESET_PC, 8'h00: PC value loaded on reset
- CNT_W, 16: width of retired-instruction counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  level; 1 = fetch and execute, 0 = stop at next instruction boundary
- ram_rd  out  1  RAM read strobe; data is returned one cycle later
- ram_addr  out  8  RAM read address (equals current PC while ram_rd=1)
- ram_rdata  in  8  RAM read data, valid the cycle after ram_rd
- zero_flag  in  1  ALU zero flag, sampled in DISPATCH for JZ
- cmd_word  out  24  {opcode, operand1, operand2}, stable while cmd_valid=1
- cmd_valid  out  1  command offered to the control unit
- cmd_ready  in  1  control unit accepts/completes command
- pc  out  8  current program counter
- halted  out  1  1 while in HALT
- busy  out  1  1 in any state other than IDLE/HALT
- retired  out  CNT_W  instructions completed since reset, saturating

## Operation
- States: IDLE, F0, F1, F2, F3, DISPATCH, HALT.
- IDLE: outputs quiet; run=1 -> F0.
- F0: ram_rd=1, ram_addr=pc, pc<=pc+1 -> F1.
- F1: opcode<=ram_rdata; ram_rd=1, ram_addr=pc, pc<=pc+1 -> F2.
- F2: operand1<=ram_rdata; ram_rd=1, ram_addr=pc, pc<=pc+1 -> F3.
- F3: operand2<=ram_rdata; no read -> DISPATCH.
- DISPATCH, by opcode:
  - 8'h00 NOP: retire, no cmd_valid.
  - 8'h80 JMP: pc<=operand1, retire.
  - 8'h81 JZ: if zero_flag then pc<=operand1; retire.
  - 8'hFF HALT: retire, -> HALT.
  - any other opcode: cmd_valid=1; stay until cmd_ready=1; retire on the cycle cmd_valid&&cmd_ready.
  - after retire (except HALT): run=1 -> F0, run=0 -> IDLE.
- HALT: terminal; only rst leaves it; run ignored.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00, so an instruction starting at 8'hFE fetches FE, FF, 00.
- retired increments by 1 per retire and saturates at all-ones.
- run=0 during F0..F3 or while waiting on cmd_ready never aborts; the current instruction completes first.
- cmd_word holds the last instruction after dispatch (not cleared).

## Timing
- Reset (rst=1 at an edge, any state, including mid-fetch or with cmd_valid high): state=IDLE, pc=RESET_PC, cmd_word=0, cmd_valid=0, ram_rd=0, ram_addr=0, halted=0, busy=0, retired=0. An outstanding read return is ignored.
- ram_rd and ram_addr are registered-state decodes: ram_addr=pc in F0/F1/F2, 0 otherwise.
- Fetch latency: F0 to DISPATCH = 4 cycles; min instruction period = 5 cycles (cmd_ready held high, or local opcode).
- cmd_valid rises the cycle DISPATCH is entered; drops the cycle after the handshake; must not toggle while waiting.
- cmd_ready without cmd_valid is ignored.
- JMP/JZ target is visible on pc the cycle after DISPATCH; next F0 reads the target.

## Test plan
- Reset/idle: rst=1 two cycles, run=0 -> all outputs at reset values; no ram_rd for 10 cycles.
- Basic fetch: RAM[0..2]=01,00,02, cmd_ready=1, run=1 -> ram_addr 0,1,2 in consecutive cycles, cmd_word=24'h010002 with cmd_valid one cycle, pc=3, retired=1.
- Backpressure: cmd_ready low 4 cycles in DISPATCH -> cmd_valid held high, cmd_word stable, no ram_rd; retire on first cmd_ready=1.
- Control flow: RAM[0..2]=81,09,00 with zero_flag=1 -> pc=9; same with zero_flag=0 -> pc=3; RAM[9..11]=FF,00,00 -> halted=1, busy=0, no further reads even with run=1.
- Wrap-around: RESET_PC=8'hFE, RAM[FE]=01, RAM[FF]=05, RAM[00]=06 -> cmd_word=24'h010506, pc=8'h01.
- Stop and reset mid-op: drop run in F1 -> instruction completes, then IDLE; assert rst while cmd_valid=1 -> next cycle cmd_valid=0, pc=RESET_PC, retired=0.
